bidir_pio_irq: RTL and testbench

BIDIR_PIO_IRQ -- requirements
Module: bidir_pio_irq

---
 rtl/bidir_pio_irq_pkg.sv | 17 +
 rtl/pio_input_sync.sv | 54 +++++
 rtl/bidir_pio_irq.sv | 115 +++++++++++
 tb/tb_bidir_pio_irq.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bidir_pio_irq_pkg.sv
// Shared constants for the bidirectional PIO block: register map and edge-capture modes.
package bidir_pio_irq_pkg;

  // Register addresses
  localparam logic [2:0] AddrData    = 3'd0;
  localparam logic [2:0] AddrDir     = 3'd1;
  localparam logic [2:0] AddrIrqMask = 3'd2;
  localparam logic [2:0] AddrEdgeCap = 3'd3;
  localparam logic [2:0] AddrOutSet  = 3'd4;
  localparam logic [2:0] AddrOutClr  = 3'd5;

  // EDGE_TYPE encodings
  localparam int unsigned EdgeRise = 0;
  localparam int unsigned EdgeFall = 1;
  localparam int unsigned EdgeAny  = 2;

endpackage

// File: rtl/pio_input_sync.sv
// Pad input synchroniser with one-cycle history and per-bit edge detection.
module pio_input_sync
  import bidir_pio_irq_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = EdgeRise
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] pad_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] edge_o
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;

  assign sync_q = stage_q[SYNC_STAGES-1];
  assign sync_o = sync_q;

  // Shift the pad level through the synchroniser chain and keep last cycle's value.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= '0;
      end
      prev_q <= '0;
    end else begin
      stage_q[0] <= pad_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
      prev_q <= sync_q;
    end
  end

  // Select the edge flavour fixed at elaboration.
  always_comb begin
    rise = sync_q & ~prev_q;
    fall = ~sync_q & prev_q;
    if (EDGE_TYPE == EdgeRise) begin
      edge_o = rise;
    end else if (EDGE_TYPE == EdgeFall) begin
      edge_o = fall;
    end else begin
      edge_o = rise ^ fall;
    end
  end

endmodule

// File: rtl/bidir_pio_irq.sv
// Memory-mapped bidirectional PIO with per-bit direction, edge capture and level irq.
module bidir_pio_irq
  import bidir_pio_irq_pkg::*;
#(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter int unsigned      EDGE_TYPE   = EdgeRise,
  parameter logic [WIDTH-1:0] RESET_OUT   = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  inout  wire  [WIDTH-1:0] bidir_port
);

  // Capture stays disabled until the synchroniser has flushed its reset contents.
  localparam logic [2:0] ArmCount = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [2:0]       arm_cnt_q, arm_cnt_d;
  logic [31:0]      readdata_q, readdata_d;

  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] edges;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] clr;
  logic             wr;
  logic             armed;
  logic             unused_wdata;

  // Upper writedata bits are deliberately ignored.
  assign unused_wdata = ^writedata;

  pio_input_sync #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_TYPE  (EDGE_TYPE)
  ) u_input_sync (
    .clk_i (clk),
    .rst_i (reset),
    .pad_i (bidir_port),
    .sync_o(sync),
    .edge_o(edges)
  );

  // Per-bit tri-state pad drivers.
  for (genvar i = 0; i < WIDTH; i++) begin : g_pad
    assign bidir_port[i] = dir_q[i] ? data_out_q[i] : 1'bz;
  end

  assign wr    = chipselect & ~write_n;
  assign wdata = writedata[WIDTH-1:0];
  assign armed = (arm_cnt_q == ArmCount);

  // Register writes, edge capture with edge-over-clear priority, and the read mux.
  always_comb begin
    data_out_d = data_out_q;
    dir_d      = dir_q;
    irqmask_d  = irqmask_q;
    clr        = '0;
    if (wr) begin
      case (address)
        AddrData:    data_out_d = wdata;
        AddrDir:     dir_d      = wdata;
        AddrIrqMask: irqmask_d  = wdata;
        AddrEdgeCap: clr        = wdata;
        AddrOutSet:  data_out_d = data_out_q | wdata;
        AddrOutClr:  data_out_d = data_out_q & ~wdata;
        default:     ;
      endcase
    end
    edgecap_d = (edgecap_q & ~clr) | (armed ? edges : '0);
    arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q + 3'd1;

    readdata_d = '0;
    case (address)
      AddrData:    readdata_d[WIDTH-1:0] = sync;
      AddrDir:     readdata_d[WIDTH-1:0] = dir_q;
      AddrIrqMask: readdata_d[WIDTH-1:0] = irqmask_q;
      AddrEdgeCap: readdata_d[WIDTH-1:0] = edgecap_q;
      default:     ;
    endcase
  end

  // State and registered read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out_q <= RESET_OUT;
      dir_q      <= '0;
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      arm_cnt_q  <= '0;
      readdata_q <= '0;
    end else begin
      data_out_q <= data_out_d;
      dir_q      <= dir_d;
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      arm_cnt_q  <= arm_cnt_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_bidir_pio_irq.sv
// Self-checking bench for bidir_pio_irq (WIDTH=8, SYNC_STAGES=2, rising-edge capture).
module tb_bidir_pio_irq;
  import bidir_pio_irq_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  wire  [31:0] readdata;
  wire         irq;
  wire  [7:0]  pad;

  logic        tb_en;
  logic [7:0]  tb_val;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q [$];
  logic [31:0] exp;

  // External pad driver plus pull-ups, so a released pad reads 1.
  assign pad = tb_en ? tb_val : 8'hzz;
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (pad[g]);
  end

  bidir_pio_irq #(
    .WIDTH      (8),
    .SYNC_STAGES(2),
    .EDGE_TYPE  (0),
    .RESET_OUT  (8'h00)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .irq       (irq),
    .bidir_port(pad)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    tb_en      = 1'b0;
    tb_val     = 8'h00;
    address    = AddrData;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    tick();
    tick();
    checks++;
    if (readdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_readdata got=%h exp=%h", readdata, 32'h0);
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq got=%b exp=0", irq);
    end
    checks++;
    if (pad !== 8'hff) begin
      errors++;
      $display("FAIL reset_pads_released got=%h exp=ff", pad);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_data_rw();
    bus_write(AddrDir, 32'hff);
    checks++;
    if (pad !== 8'h00) begin
      errors++;
      $display("FAIL dir_drive_reset_out got=%h exp=00", pad);
    end
    bus_write(AddrData, 32'hffff_ffa5);
    checks++;
    if (pad !== 8'ha5) begin
      errors++;
      $display("FAIL data_drive got=%h exp=a5", pad);
    end
    address = AddrData;
    exp_q.push_back(32'h00);
    exp_q.push_back(32'ha5);
    tick();
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (readdata !== exp) begin
      errors++;
      $display("FAIL data_read_latency2 got=%h exp=%h", readdata, exp);
    end
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (readdata !== exp) begin
      errors++;
      $display("FAIL data_read_latency3 got=%h exp=%h", readdata, exp);
    end
  endtask

  task automatic test_set_clr();
    bus_write(AddrOutSet, 32'h0a);
    checks++;
    if (pad !== 8'haf) begin
      errors++;
      $display("FAIL outset got=%h exp=af", pad);
    end
    bus_write(AddrOutClr, 32'h81);
    checks++;
    if (pad !== 8'h2e) begin
      errors++;
      $display("FAIL outclr got=%h exp=2e", pad);
    end
    for (int a = 4; a <= 7; a++) begin
      address = 3'(a);
      exp_q.push_back(32'h0);
      tick();
      exp = exp_q.pop_front();
      checks++;
      if (readdata !== exp) begin
        errors++;
        $display("FAIL read_addr%0d_zero got=%h exp=%h", a, readdata, exp);
      end
    end
    address = AddrDir;
    exp_q.push_back(32'hff);
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (readdata !== exp) begin
      errors++;
      $display("FAIL dir_read got=%h exp=%h", readdata, exp);
    end
    address = AddrData;
    exp_q.push_back(32'h2e);
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (readdata !== exp) begin
      errors++;
      $display("FAIL data_read_after_setclr got=%h exp=%h", readdata, exp);
    end
  endtask

  task automatic test_edge_irq();
    bus_write(AddrDir, 32'h0);
    tb_val = 8'h00;
    tb_en  = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    bus_write(AddrEdgeCap, 32'hff);
    bus_write(AddrIrqMask, 32'h01);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_idle got=%b exp=0", irq);
    end
    address = AddrEdgeCap;
    exp_q.push_back(32'h0);
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (readdata !== exp) begin
      errors++;
      $display("FAIL edgecap_idle got=%h exp=%h", readdata, exp);
    end
    tb_val = 8'h01;
    tick();
    tick();
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_too_early got=%b exp=0", irq);
    end
    tick();
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_after_3_edges got=%b exp=1", irq);
    end
    exp_q.push_back(32'h01);
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (readdata !== exp) begin
      errors++;
      $display("FAIL edgecap_rise got=%h exp=%h", readdata, exp);
    end
    bus_write(AddrEdgeCap, 32'h01);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_after_clear got=%b exp=0", irq);
    end
    exp_q.push_back(32'h0);
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (readdata !== exp) begin
      errors++;
      $display("FAIL edgecap_cleared got=%h exp=%h", readdata, exp);
    end
  endtask

  task automatic test_w1c_collision();
    tb_val = 8'h03;
    tick();
    tick();
    // This write lands on the same edge that captures bit1.
    bus_write(AddrEdgeCap, 32'h02);
    address = AddrEdgeCap;
    exp_q.push_back(32'h02);
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (readdata !== exp) begin
      errors++;
      $display("FAIL w1c_collision got=%h exp=%h", readdata, exp);
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_unmasked_bit got=%b exp=0", irq);
    end
    bus_write(AddrEdgeCap, 32'hff);
    tb_val = 8'h00;
    for (int i = 0; i < 5; i++) tick();
    address = AddrEdgeCap;
    exp_q.push_back(32'h0);
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (readdata !== exp) begin
      errors++;
      $display("FAIL falling_ignored got=%h exp=%h", readdata, exp);
    end
  endtask

  task automatic test_reset_arming();
    tb_val = 8'hff;
    tb_en  = 1'b1;
    reset  = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    bus_write(AddrIrqMask, 32'hff);
    address = AddrEdgeCap;
    for (int i = 0; i < 12; i++) begin
      exp_q.push_back(32'h0);
      tick();
      exp = exp_q.pop_front();
      checks++;
      if (readdata !== exp) begin
        errors++;
        $display("FAIL arming_edgecap cycle=%0d got=%h exp=%h", i, readdata, exp);
      end
      checks++;
      if (irq !== 1'b0) begin
        errors++;
        $display("FAIL arming_irq cycle=%0d got=%b exp=0", i, irq);
      end
    end
  endtask

  task automatic test_reset_async();
    tb_en = 1'b0;
    bus_write(AddrDir, 32'hff);
    bus_write(AddrData, 32'h3c);
    tick();
    tick();
    tick();
    address = AddrEdgeCap;
    exp_q.push_back(32'h3c);
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (readdata !== exp) begin
      errors++;
      $display("FAIL edgecap_3c got=%h exp=%h", readdata, exp);
    end
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_3c got=%b exp=1", irq);
    end
    // Assert reset between clock edges and look before any edge arrives.
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (pad !== 8'hff) begin
      errors++;
      $display("FAIL async_reset_pads got=%h exp=ff", pad);
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_irq got=%b exp=0", irq);
    end
    checks++;
    if (readdata !== 32'h0) begin
      errors++;
      $display("FAIL async_reset_readdata got=%h exp=0", readdata);
    end
    tick();
    reset   = 1'b0;
    address = AddrEdgeCap;
    exp_q.push_back(32'h0);
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (readdata !== exp) begin
      errors++;
      $display("FAIL async_reset_edgecap got=%h exp=%h", readdata, exp);
    end
  endtask

  initial begin
    test_reset();
    test_data_rw();
    test_set_clr();
    test_edge_irq();
    test_w1c_collision();
    test_reset_arming();
    test_reset_async();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
